i2c_target: RTL and testbench

- I2C target (slave) responder: the other end of the bus driven by the team's CF_I2C_WB master on gpio8 (SCL) and gpio9 (SDA).
- EEPROM-style byte register model with a 7-bit address:
  - The first written byte after the address sets an internal pointer.
  - Later writes store bytes at the pointer; reads return bytes from the pointer.
  - The pointer auto-increments after every access.
- Exposes a simple synchronous register port to a user-side byte memory. Used for on-chip loopback testing of the master and as a user-project peripheral.

---
 rtl/i2c_target_pkg.sv | 19 +
 rtl/i2c_bus_monitor.sv | 45 ++++
 rtl/i2c_target.sv | 195 +++++++++++++++++++
 tb/tb_i2c_target.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and bus-level constants for the i2c_target responder.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    RD_WAIT
  } state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// SCL/SDA synchronizers with edge and START/STOP detection in the clk_i domain.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SCL must be high in both the current and previous sample so an SCL edge is never mistaken for START/STOP
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// EEPROM-style I2C target: first written byte loads the pointer, later bytes
// are written/read at the pointer, which auto-increments after every access.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  ADDR        = 7'h50,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_oen_o,
  output logic [REG_AW-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              reg_re_o,
  output logic              busy_o
);

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] rx_byte;
  logic       rw;
  logic       first_byte;
  logic       ptr_inc;

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  assign sda_o   = 1'b0;
  assign rx_byte = {shreg[6:0], sda_s};

  // The ADDR parameter shadows the imported state name, so the state is always package-qualified.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      rw          <= 1'b0;
      first_byte  <= 1'b0;
      ptr_inc     <= 1'b0;
      sda_oen_o   <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      reg_we_o <= 1'b0;
      reg_re_o <= 1'b0;
      ptr_inc  <= 1'b0;
      if (ptr_inc) begin
        reg_addr_o <= reg_addr_o + REG_AW'(1);
      end

      if (start_det) begin
        state     <= i2c_target_pkg::ADDR;
        bit_cnt   <= '0;
        sda_oen_o <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        sda_oen_o <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;

          i2c_target_pkg::ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (rx_byte[7:1] == ADDR) begin
                  rw     <= rx_byte[0];
                  busy_o <= 1'b1;
                  state  <= ADDR_ACK;
                end else begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oen_o <= ~I2C_ACK;
                bit_cnt   <= 4'd1;
              end else if (rw == I2C_RW_READ) begin
                shreg     <= reg_rdata_i;
                reg_re_o  <= 1'b1;
                ptr_inc   <= 1'b1;
                sda_oen_o <= ~reg_rdata_i[7];
                bit_cnt   <= 4'd1;
                state     <= RD_DATA;
              end else begin
                sda_oen_o  <= 1'b0;
                first_byte <= 1'b1;
                bit_cnt    <= '0;
                state      <= WR_DATA;
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                state   <= WR_ACK;
                if (first_byte) begin
                  reg_addr_o <= rx_byte[REG_AW-1:0];
                  first_byte <= 1'b0;
                end else begin
                  reg_wdata_o <= rx_byte;
                  reg_we_o    <= 1'b1;
                  ptr_inc     <= 1'b1;
                end
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oen_o <= ~I2C_ACK;
                bit_cnt   <= 4'd1;
              end else begin
                sda_oen_o <= 1'b0;
                bit_cnt   <= '0;
                state     <= WR_DATA;
              end
            end
          end

          // bit_cnt counts bits already placed on the bus; bit 7 goes out at load time
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oen_o <= 1'b0;
                bit_cnt   <= '0;
                state     <= RD_ACK;
              end else begin
                shreg     <= {shreg[6:0], 1'b0};
                sda_oen_o <= ~shreg[6];
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise && sda_s == I2C_NACK) begin
              state <= RD_WAIT;
            end else if (scl_fall) begin
              shreg     <= reg_rdata_i;
              reg_re_o  <= 1'b1;
              ptr_inc   <= 1'b1;
              sda_oen_o <= ~reg_rdata_i[7];
              bit_cnt   <= 4'd1;
              state     <= RD_DATA;
            end
          end

          RD_WAIT: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a behavioural bus master plus a byte memory on the register port.
module tb_i2c_target;
  timeunit 1ns;
  timeprecision 1ps;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_o;
  logic       sda_oen_o;
  logic [3:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic [7:0] reg_rdata_i;
  logic       reg_re_o;
  logic       busy_o;

  logic [7:0] mem [16];
  logic [3:0] we_addr_log [32];
  logic [7:0] we_data_log [32];
  int we_cnt = 0;
  int re_cnt = 0;
  int oen_cnt = 0;
  int busy_cnt = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign sda_line    = sda_m & ~sda_oen_o;
  assign reg_rdata_i = mem[reg_addr_o];

  i2c_target #(
    .ADDR(7'h50),
    .REG_AW(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_oen_o  (sda_oen_o),
    .reg_addr_o (reg_addr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_we_o   (reg_we_o),
    .reg_rdata_i(reg_rdata_i),
    .reg_re_o   (reg_re_o),
    .busy_o     (busy_o)
  );

  always @(posedge clk) begin
    if (reg_we_o) begin
      mem[reg_addr_o]     <= reg_wdata_o;
      we_addr_log[we_cnt] <= reg_addr_o;
      we_data_log[we_cnt] <= reg_wdata_o;
      we_cnt              <= we_cnt + 1;
    end
    if (reg_re_o)  re_cnt   <= re_cnt + 1;
    if (sda_oen_o) oen_cnt  <= oen_cnt + 1;
    if (busy_o)    busy_cnt <= busy_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(8); sda_m = 1'b0;
    wait_clk(8); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wait_clk(4); sda_m = 1'b0;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(8); sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bit(input logic b, output logic oen_hi);
    wait_clk(4); sda_m = b;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(4); oen_hi = sda_oen_o;
    wait_clk(4); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b, output logic oen_hi);
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4); scl_m = 1'b1;
    wait_clk(4); b = sda_line; oen_hi = sda_oen_o;
    wait_clk(4); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack_line, output logic ack_oen);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(v[i], dummy);
    read_bit(ack_line, ack_oen);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic dummy;
    for (int i = 7; i >= 0; i--) read_bit(v[i], dummy);
  endtask

  task automatic test_reset();
    n_cmp++; if (sda_oen_o !== 1'b0) begin n_fail++; $display("FAIL reset_oen: got %b expected 0", sda_oen_o); end
    n_cmp++; if (sda_o !== 1'b0) begin n_fail++; $display("FAIL reset_sda_o: got %b expected 0", sda_o); end
    n_cmp++; if (reg_addr_o !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", reg_addr_o); end
    n_cmp++; if (reg_we_o !== 1'b0 || reg_re_o !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got we=%b re=%b expected 0 0", reg_we_o, reg_re_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_write();
    logic [7:0] seq [4];
    logic ln, oe;
    int we0;
    seq = '{8'hA0, 8'h03, 8'h5A, 8'hC3};
    we0 = we_cnt;
    start_c();
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i], ln, oe);
      n_cmp++; if (oe !== 1'b1 || ln !== 1'b0) begin n_fail++; $display("FAIL wr_ack%0d: got oen=%b line=%b expected oen=1 line=0", i, oe, ln); end
      if (i == 0) begin
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", busy_o); end
      end
    end
    stop_c();
    n_cmp++; if (we_cnt - we0 !== 2) begin n_fail++; $display("FAIL wr_we_count: got %0d expected 2", we_cnt - we0); end
    n_cmp++; if (we_addr_log[we0] !== 4'h3 || we_data_log[we0] !== 8'h5A) begin n_fail++; $display("FAIL wr_first: got %h/%h expected 3/5a", we_addr_log[we0], we_data_log[we0]); end
    n_cmp++; if (we_addr_log[we0+1] !== 4'h4 || we_data_log[we0+1] !== 8'hC3) begin n_fail++; $display("FAIL wr_second: got %h/%h expected 4/c3", we_addr_log[we0+1], we_data_log[we0+1]); end
    n_cmp++; if (reg_addr_o !== 4'h5) begin n_fail++; $display("FAIL wr_ptr: got %h expected 5", reg_addr_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop: got %b expected 0", busy_o); end
  endtask

  task automatic test_read();
    logic ln, oe, oen_a, oen_n;
    logic [7:0] b1, b2;
    int re0;
    start_c();
    send_byte(8'hA0, ln, oe);
    send_byte(8'h02, ln, oe);
    send_byte(8'h11, ln, oe);
    send_byte(8'h22, ln, oe);
    stop_c();
    re0 = re_cnt;
    start_c();
    send_byte(8'hA0, ln, oe);
    send_byte(8'h02, ln, oe);
    start_c();
    send_byte(8'hA1, ln, oe);
    n_cmp++; if (ln !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b expected 0", ln); end
    read_byte(b1);
    send_bit(1'b0, oen_a);
    read_byte(b2);
    send_bit(1'b1, oen_n);
    stop_c();
    n_cmp++; if (b1 !== 8'h11) begin n_fail++; $display("FAIL rd_byte1: got %h expected 11", b1); end
    n_cmp++; if (b2 !== 8'h22) begin n_fail++; $display("FAIL rd_byte2: got %h expected 22", b2); end
    n_cmp++; if (re_cnt - re0 !== 2) begin n_fail++; $display("FAIL rd_re_count: got %0d expected 2", re_cnt - re0); end
    n_cmp++; if (reg_addr_o !== 4'h4) begin n_fail++; $display("FAIL rd_ptr: got %h expected 4", reg_addr_o); end
    n_cmp++; if (oen_a !== 1'b0 || oen_n !== 1'b0) begin n_fail++; $display("FAIL rd_master_ack_release: got %b %b expected 0 0", oen_a, oen_n); end
  endtask

  task automatic test_mismatch();
    logic ln, oe;
    int we0, re0, oen0, busy0;
    we0 = we_cnt; re0 = re_cnt; oen0 = oen_cnt; busy0 = busy_cnt;
    start_c();
    send_byte(8'hA2, ln, oe);
    n_cmp++; if (ln !== 1'b1) begin n_fail++; $display("FAIL mm_nack: got %b expected 1", ln); end
    send_byte(8'h55, ln, oe);
    stop_c();
    n_cmp++; if (oen_cnt != oen0) begin n_fail++; $display("FAIL mm_sda_driven: got %0d cycles expected 0", oen_cnt - oen0); end
    n_cmp++; if (we_cnt != we0 || re_cnt != re0) begin n_fail++; $display("FAIL mm_strobes: got we=%0d re=%0d expected 0 0", we_cnt - we0, re_cnt - re0); end
    n_cmp++; if (busy_cnt != busy0) begin n_fail++; $display("FAIL mm_busy: got %0d cycles expected 0", busy_cnt - busy0); end
  endtask

  task automatic test_wrap();
    logic ln, oe;
    int we0;
    we0 = we_cnt;
    start_c();
    send_byte(8'hA0, ln, oe);
    send_byte(8'h0F, ln, oe);
    send_byte(8'hAA, ln, oe);
    send_byte(8'hBB, ln, oe);
    stop_c();
    n_cmp++; if (we_addr_log[we0] !== 4'hF || we_data_log[we0] !== 8'hAA) begin n_fail++; $display("FAIL wrap_first: got %h/%h expected f/aa", we_addr_log[we0], we_data_log[we0]); end
    n_cmp++; if (we_addr_log[we0+1] !== 4'h0 || we_data_log[we0+1] !== 8'hBB) begin n_fail++; $display("FAIL wrap_second: got %h/%h expected 0/bb", we_addr_log[we0+1], we_data_log[we0+1]); end
    n_cmp++; if (reg_addr_o !== 4'h1) begin n_fail++; $display("FAIL wrap_ptr: got %h expected 1", reg_addr_o); end
  endtask

  task automatic test_stop_mid_byte();
    logic ln, oe, dummy;
    int we0;
    we0 = we_cnt;
    start_c();
    send_byte(8'hA0, ln, oe);
    send_byte(8'h00, ln, oe);
    send_bit(1'b1, dummy);
    send_bit(1'b0, dummy);
    send_bit(1'b1, dummy);
    send_bit(1'b1, dummy);
    stop_c();
    n_cmp++; if (we_cnt != we0) begin n_fail++; $display("FAIL smb_we: got %0d expected 0", we_cnt - we0); end
    n_cmp++; if (busy_o !== 1'b0 || sda_oen_o !== 1'b0) begin n_fail++; $display("FAIL smb_idle: got busy=%b oen=%b expected 0 0", busy_o, sda_oen_o); end
    n_cmp++; if (reg_addr_o !== 4'h0) begin n_fail++; $display("FAIL smb_ptr: got %h expected 0", reg_addr_o); end
    start_c();
    send_byte(8'hA0, ln, oe);
    n_cmp++; if (ln !== 1'b0 || oe !== 1'b1) begin n_fail++; $display("FAIL smb_next_ack: got line=%b oen=%b expected 0 1", ln, oe); end
    stop_c();
  endtask

  task automatic test_reset_mid_read();
    logic ln, oe, dummy;
    logic [7:0] b;
    start_c();
    send_byte(8'hA0, ln, oe);
    send_byte(8'h03, ln, oe);
    start_c();
    send_byte(8'hA1, ln, oe);
    wait_clk(6);
    n_cmp++; if (sda_oen_o !== 1'b1) begin n_fail++; $display("FAIL rmr_driving: got %b expected 1", sda_oen_o); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (sda_oen_o !== 1'b0) begin n_fail++; $display("FAIL rmr_async_release: got %b expected 0", sda_oen_o); end
    n_cmp++; if (reg_addr_o !== 4'h0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rmr_ptr_busy: got ptr=%h busy=%b expected 0 0", reg_addr_o, busy_o); end
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    stop_c();
    start_c();
    send_byte(8'hA1, ln, oe);
    read_byte(b);
    send_bit(1'b1, dummy);
    stop_c();
    n_cmp++; if (b !== 8'hBB) begin n_fail++; $display("FAIL rmr_read_mem0: got %h expected bb", b); end
    n_cmp++; if (reg_addr_o !== 4'h1) begin n_fail++; $display("FAIL rmr_ptr_after: got %h expected 1", reg_addr_o); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_stop_mid_byte();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
